// File: rtl/muldiv_seq.sv
// muldiv_seq -- iterative RV32M multiply/divide sequencer.
//
// Takes one M-extension op, stalls the pipeline via busy_o while a 32-step
// shift-add multiply or restoring divide runs on unsigned magnitudes, then
// applies sign correction and special-case overrides. The result is returned
// with a one-cycle done_o pulse. Latency is fixed at 34 cycles for every op.
//
// Ports:
//   clk_i     core clock, rising edge
//   rst_i     synchronous active-high reset
//   start_i   request, honoured only in IDLE or DONE
//   op_i      funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a_i, b_i  rs1 / rs2 operands, sampled on the accept edge only
//   kill_i    pipeline flush, aborts the operation (beats start_i)
//   busy_o    high in CALC and FIX
//   done_o    high in DONE only
//   result_o  registered result, updated on the FIX->DONE edge
module muldiv_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        kill_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t      r_state, w_next;
  logic        w_accept;

  logic [2:0]  r_op;
  logic        r_neg_a, r_neg_b, r_bzero;
  logic [31:0] r_a;       // multiplicand / dividend magnitude (shifts left on divide)
  logic [31:0] r_b;       // multiplier (shifts right on multiply) / divisor magnitude
  logic [31:0] r_a_raw;   // original rs1, returned by REM on divide-by-zero
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;     // multiply: product; divide: {remainder, quotient}
  logic [31:0] r_result;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: if (start_i) begin w_next = S_CALC; w_accept = 1'b1; end
      S_CALC: if (r_cnt == 5'd31) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: begin
        if (start_i) begin w_next = S_CALC; w_accept = 1'b1; end
        else         w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (kill_i) begin
      w_next   = S_IDLE;
      w_accept = 1'b0;
    end
  end

  assign busy_o   = (r_state == S_CALC) || (r_state == S_FIX);
  assign done_o   = (r_state == S_DONE);
  assign result_o = r_result;

  // ---------------- operand conditioning ----------------
  logic        w_sa, w_sb;
  logic [31:0] w_a_mag, w_b_mag;

  assign w_sa    = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
  assign w_sb    = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
  assign w_a_mag = (w_sa && a_i[31]) ? (~a_i + 32'd1) : a_i;
  assign w_b_mag = (w_sb && b_i[31]) ? (~b_i + 32'd1) : b_i;

  // ---------------- iteration datapath ----------------
  logic [32:0] w_sum;   // multiply: upper half + multiplicand
  logic [32:0] w_shl;   // divide: remainder shifted left with next dividend bit
  logic [32:0] w_diff;  // divide: trial subtraction
  logic        w_ge;

  assign w_sum  = {1'b0, r_acc[63:32]} + (r_b[0] ? {1'b0, r_a} : 33'd0);
  assign w_shl  = {r_acc[63:32], r_a[31]};
  assign w_diff = w_shl - {1'b0, r_b};
  // Shifted remainder is below 2*divisor; with bit 32 set it certainly exceeds
  // any 32-bit divisor, otherwise the borrow bit of the 33-bit subtract decides.
  assign w_ge   = w_shl[32] | ~w_diff[32];

  // ---------------- sign correction / special cases ----------------
  logic        w_flip;
  logic [63:0] w_prod;
  logic [31:0] w_quo, w_rem, w_fix;

  assign w_flip = r_neg_a ^ r_neg_b;
  assign w_prod = w_flip  ? (~r_acc + 64'd1)        : r_acc;
  assign w_quo  = w_flip  ? (~r_acc[31:0] + 32'd1)  : r_acc[31:0];
  assign w_rem  = r_neg_a ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

  // Signed overflow (0x80000000 / -1) falls out of the magnitude path:
  // quotient 0x80000000 negated wraps to itself, remainder is 0.
  always_comb begin
    w_fix = 32'd0;
    case (r_op)
      3'b000:                 w_fix = w_prod[31:0];
      3'b001, 3'b010, 3'b011: w_fix = w_prod[63:32];
      3'b100, 3'b101:         w_fix = r_bzero ? 32'hFFFF_FFFF : w_quo;
      default:                w_fix = r_bzero ? r_a_raw : w_rem;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op     <= 3'd0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_bzero  <= 1'b0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_a_raw  <= 32'd0;
      r_cnt    <= 5'd0;
      r_acc    <= 64'd0;
      r_result <= 32'd0;
    end else begin
      if (w_accept) begin
        r_op    <= op_i;
        r_neg_a <= w_sa & a_i[31];
        r_neg_b <= w_sb & b_i[31];
        r_bzero <= (b_i == 32'd0);
        r_a     <= w_a_mag;
        r_b     <= w_b_mag;
        r_a_raw <= a_i;
        r_cnt   <= 5'd0;
        r_acc   <= 64'd0;
      end else if (r_state == S_CALC && !kill_i) begin
        r_cnt <= r_cnt + 5'd1;
        if (r_op[2]) begin
          r_acc <= {(w_ge ? w_diff[31:0] : w_shl[31:0]), r_acc[30:0], w_ge};
          r_a   <= {r_a[30:0], 1'b0};
        end else begin
          r_acc <= {w_sum, r_acc[31:1]};
          r_b   <= {1'b0, r_b[31:1]};
        end
      end
      if (r_state == S_FIX && !kill_i) r_result <= w_fix;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected results are queued when an op is
// issued and compared whenever done_o is seen. Latency, busy window, flush,
// mid-op reset, back-to-back issue and ignored mid-CALC starts are covered.
module tb_muldiv_seq;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, kill = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        busy, done;
  logic [31:0] res;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .kill_i(kill), .busy_o(busy), .done_o(done), .result_o(res)
  );

  int          nchk = 0, nerr = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_exp = 32'd0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Independent reference built on 64-bit host arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, uy, p;
    logic [63:0]     up;
    logic [31:0]     r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    uy = longint'({32'd0, y});
    r  = 32'd0;
    case (o)
      3'd0: begin p = sx * sy; r = p[31:0]; end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * uy; r = p[63:32]; end
      3'd3: begin up = {32'd0, x} * {32'd0, y}; r = up[63:32]; end
      3'd4: begin
        if (y == 32'd0) r = 32'hFFFF_FFFF;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = $signed(x) / $signed(y);
      end
      3'd5: r = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 32'd0) r = x;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
        else r = $signed(x) % $signed(y);
      end
      default: r = (y == 32'd0) ? x : x % y;
    endcase
    return r;
  endfunction

  // Result checker driven by done_o.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else chk("result", res, sb_q.pop_front());
    end
  end

  // Issue one op. now=1 drives start in the current cycle (used back-to-back
  // from DONE); poke=1 pulses start with junk operands mid-CALC.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] e, input bit now, input bit poke);
    int n, nb;
    if (!now) @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    sb_q.push_back(e);
    last_exp = e;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    n = 1; nb = 0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    chk("no_done_after_accept", {31'd0, done}, 32'd0);
    while (!done && n < 60) begin
      if (busy) nb++;
      start = poke && (n == 10);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("latency", n, 32'd34);
    chk("busy_cycles", nb, 32'd33);
  endtask

  // Start a DIV, then flush (kill with a same-cycle start) or reset at cycle 10.
  task automatic do_abort(input bit use_rst);
    @(negedge clk);
    op = 3'd4; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    if (use_rst) rst = 1'b1;
    else begin kill = 1'b1; start = 1'b1; end
    @(negedge clk);
    rst = 1'b0; kill = 1'b0; start = 1'b0;
    chk(use_rst ? "rst_busy" : "kill_busy", {31'd0, busy}, 32'd0);
    chk(use_rst ? "rst_done" : "kill_done", {31'd0, done}, 32'd0);
    if (use_rst) last_exp = 32'd0;
    chk(use_rst ? "rst_result" : "kill_result", res, last_exp);
  endtask

  logic [2:0]  ro;
  logic [31:0] ra, rb;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", res, 32'd0);
    rst = 1'b0;

    do_op(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(3'd5, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0);
    do_op(3'd7, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0);
    do_op(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(3'd7, 32'd5,         32'd0,         32'd5,         1'b0, 1'b0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0);
    do_op(3'd4, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(3'd6, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 1'b0, 1'b0);

    do_abort(1'b0);
    do_op(3'd0, 32'd3, 32'd4, 32'd12, 1'b1, 1'b0);
    do_abort(1'b1);
    do_op(3'd0, 32'd3, 32'd4, 32'd12, 1'b1, 1'b0);

    // Back-to-back chain with a stray start pulse inside the second op.
    do_op(3'd0, 32'd6,   32'd9, 32'd54, 1'b0, 1'b0);
    do_op(3'd5, 32'd200, 32'd9, 32'd22, 1'b1, 1'b1);
    do_op(3'd7, 32'd200, 32'd9, 32'd2,  1'b1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ro = 3'(i);
      ra = $urandom;
      rb = (i % 11 == 5) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      if (i % 5 == 4) ra = 32'h8000_0000;
      do_op(ro, ra, rb, model(ro, ra, rb), (i % 2) == 1, (i % 7) == 3);
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
